// File: rtl/serial_work_loader.sv
// Assembles 64-byte Icarus work packets (32 B midstate, 20 B pad, 12 B data tail) from a UART byte stream.
// Optional inter-byte idle timeout is enabled by defining LOADER_TIMEOUT_EN.
module serial_work_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
    parameter int unsigned TIMEOUT_W      = 25
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [255:0] midstate,
    output logic [95:0]  data,
    output logic         work_valid,
    output logic         busy,
    output logic         err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_COMMIT
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [5:0]   r_byte_cnt;
    logic [5:0]   w_byte_cnt_nxt;
    logic         w_shift;
    logic         w_commit;
    logic         w_timeout;
    logic [511:0] r_sh;
    logic [255:0] r_midstate;
    logic [95:0]  r_data;
    logic         r_work_valid;

    // A named block shows up in the hierarchy when the idle counter is too narrow for the timeout.
    if (TIMEOUT_W < 1 || TIMEOUT_W > 32 ||
        (64'(1) << TIMEOUT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_timeout_w_too_small
    end

`ifdef LOADER_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] IDLE_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] r_idle_cnt;
    logic                 r_err_timeout;

    // A byte arriving on the limit cycle wins over the timeout.
    assign w_timeout = (r_state == S_RECV) && !rx_valid && (r_idle_cnt == IDLE_LIMIT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idle_cnt    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_timeout;
            if (r_state != S_RECV || rx_valid || w_timeout) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise missing branches infer latches.
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_shift        = 1'b0;
        w_commit       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    w_shift        = 1'b1;
                    w_byte_cnt_nxt = 6'd1;
                    w_state_nxt    = S_RECV;
                end
            end
            S_RECV: begin
                if (rx_valid) begin
                    w_shift        = 1'b1;
                    w_byte_cnt_nxt = r_byte_cnt + 6'd1;
                    if (r_byte_cnt == 6'd63) begin
                        w_state_nxt = S_COMMIT;
                    end
                end else if (w_timeout) begin
                    w_byte_cnt_nxt = '0;
                    w_state_nxt    = S_IDLE;
                end
            end
            S_COMMIT: begin
                w_commit       = 1'b1;
                w_byte_cnt_nxt = '0;
                w_state_nxt    = S_IDLE;
                // The next packet may start on the commit cycle; its first byte is kept.
                if (rx_valid) begin
                    w_shift        = 1'b1;
                    w_byte_cnt_nxt = 6'd1;
                    w_state_nxt    = S_RECV;
                end
            end
            default: begin
                w_byte_cnt_nxt = '0;
                w_state_nxt    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the packet buffer is cleared on reset so a partial packet never leaks into a later one.
            r_sh         <= '0;
            r_midstate   <= '0;
            r_data       <= '0;
            r_work_valid <= 1'b0;
        end else begin
            r_work_valid <= w_commit;
            if (w_commit) begin
                r_midstate <= r_sh[255:0];
                r_data     <= r_sh[511:416];
            end
            if (w_shift) begin
                r_sh <= {rx_data, r_sh[511:8]};
            end
        end
    end

    assign midstate   = r_midstate;
    assign data       = r_data;
    assign work_valid = r_work_valid;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_work_loader.sv
// Scoreboard bench for serial_work_loader: directed packets push expected work, a monitor pops on each strobe.
// Timeout scenarios run only when LOADER_TIMEOUT_EN is defined.
module tb_serial_work_loader;

    typedef struct {
        logic [255:0] ms;
        logic [95:0]  d;
        int           cyc;
    } exp_t;

    localparam logic [255:0] MS1 = 256'h635ef71f2ce00832a4b416afc1945ba0d775d72163ab4d6815c08d6e1620437b;
    localparam logic [95:0]  D1  = 96'he5e1081ae9a4374e1e8d8d13;
    localparam logic [255:0] MS2 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [95:0]  D2  = 96'h3f3e3d3c3b3a393837363534;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic [255:0] midstate;
    logic [95:0]  data;
    logic         work_valid;
    logic         busy;
    logic         err_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic rst_hit = 1'b1;
    logic mon_en  = 1'b0;
    logic [255:0] prev_ms = '0;
    logic [95:0]  prev_d  = '0;

    exp_t q_work[$];
    int   q_to[$];

    logic [7:0] p1[64];
    logic [7:0] p2[64];
    logic [7:0] hd[32] = '{8'h7b, 8'h43, 8'h20, 8'h16, 8'h6e, 8'h8d, 8'hc0, 8'h15,
                           8'h68, 8'h4d, 8'hab, 8'h63, 8'h21, 8'hd7, 8'h75, 8'hd7,
                           8'ha0, 8'h5b, 8'h94, 8'hc1, 8'haf, 8'h16, 8'hb4, 8'ha4,
                           8'h32, 8'h08, 8'he0, 8'h2c, 8'h1f, 8'hf7, 8'h5e, 8'h63};
    logic [7:0] tl[12] = '{8'h13, 8'h8d, 8'h8d, 8'h1e, 8'h4e, 8'h37,
                           8'ha4, 8'he9, 8'h1a, 8'h08, 8'he1, 8'he5};

    serial_work_loader #(
        .TIMEOUT_CYCLES(100),
        .TIMEOUT_W     (7)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .midstate   (midstate),
        .data       (data),
        .work_valid (work_valid),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rst_hit = !reset_n;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one byte at a falling edge, then leaves gap idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_packet(input logic [7:0] pkt[64], input int gap,
                               input logic [255:0] ems, input logic [95:0] ed);
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) begin
                e.ms  = ems;
                e.d   = ed;
                e.cyc = cyc + 2;
                q_work.push_back(e);
            end
            send_byte(pkt[i], (i == 63) ? 0 : gap);
        end
    endtask

    // Monitor: pops expected work on every strobe, otherwise requires held outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            if (work_valid) begin
                if (q_work.size() == 0) begin
                    check("unexpected_work_valid", {255'b0, work_valid}, 256'd0);
                end else begin
                    exp_t e;
                    e = q_work.pop_front();
                    check("midstate", midstate, e.ms);
                    check("data", {160'b0, data}, {160'b0, e.d});
                    check("work_valid_cycle", 256'(cyc), 256'(e.cyc));
                end
            end else begin
                check("midstate_hold", midstate, rst_hit ? 256'd0 : prev_ms);
                check("data_hold", {160'b0, data}, rst_hit ? 256'd0 : {160'b0, prev_d});
            end
            if (err_timeout) begin
                if (q_to.size() == 0) begin
                    check("unexpected_err_timeout", {255'b0, err_timeout}, 256'd0);
                end else begin
                    check("err_timeout_cycle", 256'(cyc), 256'(q_to.pop_front()));
                end
            end
            prev_ms = midstate;
            prev_d  = data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the bench completed");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int to_cyc;
        for (int i = 0; i < 64; i++) begin
            p2[i] = 8'(i);
            if (i < 32)      p1[i] = hd[i];
            else if (i < 52) p1[i] = 8'h00;
            else             p1[i] = tl[i - 52];
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_midstate", midstate, 256'd0);
        check("rst_data", {160'b0, data}, 256'd0);
        check("rst_work_valid", {255'b0, work_valid}, 256'd0);
        check("rst_busy", {255'b0, busy}, 256'd0);
        check("rst_err_timeout", {255'b0, err_timeout}, 256'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);

        // Single packet decode
        send_packet(p1, 0, MS1, D1);
        check("t1_busy_commit", {255'b0, busy}, 256'd1);
        repeat (3) @(negedge clk);
        check("t1_busy_idle", {255'b0, busy}, 256'd0);

        // Back-to-back packets: packet 2 byte 0 lands on packet 1 commit cycle
        send_packet(p1, 0, MS1, D1);
        check("t2_busy_gap", {255'b0, busy}, 256'd1);
        send_packet(p2, 0, MS2, D2);
        check("t2_busy_commit2", {255'b0, busy}, 256'd1);
        @(negedge clk);
        check("t2_busy_after", {255'b0, busy}, 256'd0);
        repeat (3) @(negedge clk);

        // Reset mid-packet discards the partial packet and clears committed work
        for (int i = 0; i < 40; i++) send_byte(p1[i], 0);
        check("t3_busy_partial", {255'b0, busy}, 256'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("t3_midstate_cleared", midstate, 256'd0);
        check("t3_data_cleared", {160'b0, data}, 256'd0);
        check("t3_busy_cleared", {255'b0, busy}, 256'd0);
        send_packet(p1, 0, MS1, D1);
        repeat (3) @(negedge clk);

`ifdef LOADER_TIMEOUT_EN
        // Stall for 100 idle clocks: partial packet is dropped with one err_timeout pulse
        for (int i = 0; i < 10; i++) begin
            to_cyc = cyc + 101;
            send_byte(p2[i], 0);
        end
        q_to.push_back(to_cyc);
        repeat (100) @(negedge clk);
        check("t4_busy_after_timeout", {255'b0, busy}, 256'd0);
        check("t4_midstate_kept", midstate, MS1);
        send_packet(p1, 0, MS1, D1);
        repeat (3) @(negedge clk);

        // 99 idle clocks between bytes: the byte on the limit cycle wins
        send_packet(p2, 99, MS2, D2);
        repeat (3) @(negedge clk);
`else
        to_cyc = 0;
        check("t4_err_timeout_tied", {255'b0, err_timeout}, 256'(to_cyc));
`endif

        repeat (5) @(negedge clk);
        check("work_queue_drained", 256'(q_work.size()), 256'd0);
        check("timeout_queue_drained", 256'(q_to.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
